// File: rtl/pipeline_foreground_clip_ctrl_pkg.sv
// rtl/pipeline_foreground_clip_ctrl_pkg.sv - shared address map and FSM encodings for the fg clip controller
// Also used by the command decoder; optional feature macro: FG_CLIP_CLAMP_EN.
package pipeline_foreground_clip_ctrl_pkg;

  localparam int FG_CLIP_NUM_EDGES = 4;

  localparam logic [1:0] FG_CLIP_ADDR_LEFT   = 2'd0;
  localparam logic [1:0] FG_CLIP_ADDR_RIGHT  = 2'd1;
  localparam logic [1:0] FG_CLIP_ADDR_TOP    = 2'd2;
  localparam logic [1:0] FG_CLIP_ADDR_BOTTOM = 2'd3;

  typedef enum logic [1:0] {
    FG_CLIP_ST_IDLE  = 2'd0,
    FG_CLIP_ST_ARMED = 2'd1,
    FG_CLIP_ST_APPLY = 2'd2
  } fg_clip_state_t;

endpackage

// File: rtl/fg_clip_clamp.sv
// rtl/fg_clip_clamp.sv - combinational min(v, limit) for one clip edge
// With EN=0 the value passes through unchanged (unclamped build).
module fg_clip_clamp #(
  parameter int PRECISION = 11,
  parameter int LIMIT     = 800,
  parameter bit EN        = 1'b1
) (
  input  logic [PRECISION-1:0] v_i,
  output logic [PRECISION-1:0] v_o
);

  localparam logic [PRECISION-1:0] LIMIT_V = PRECISION'(LIMIT);

  assign v_o = (EN && (v_i > LIMIT_V)) ? LIMIT_V : v_i;

endmodule

// File: rtl/pipeline_foreground_clip_ctrl.sv
// rtl/pipeline_foreground_clip_ctrl.sv - double-buffered fg clip edges, applied atomically at frame_start
// Define FG_CLIP_CLAMP_EN to clamp applied edges to the active resolution.
module pipeline_foreground_clip_ctrl
  import pipeline_foreground_clip_ctrl_pkg::*;
#(
  parameter int PRECISION    = 11,
  parameter int RESOLUTION_X = 800,
  parameter int RESOLUTION_Y = 600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [1:0]           wr_addr,
  input  logic [PRECISION-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 commit_req,
  input  logic                 frame_start,
  output logic                 commit_pending,
  output logic                 commit_done,
  output logic [PRECISION-1:0] ctrl_fg_clip_left,
  output logic [PRECISION-1:0] ctrl_fg_clip_right,
  output logic [PRECISION-1:0] ctrl_fg_clip_top,
  output logic [PRECISION-1:0] ctrl_fg_clip_bottom
);

`ifdef FG_CLIP_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  fg_clip_state_t state_q, state_d;
  logic                 done_q, done_d;
  logic [PRECISION-1:0] shadow_q [FG_CLIP_NUM_EDGES];
  logic [PRECISION-1:0] active_q [FG_CLIP_NUM_EDGES];
  logic [PRECISION-1:0] applied_v [FG_CLIP_NUM_EDGES];
  logic                 wr_fire;

  assign wr_fire = wr_valid && (state_q == FG_CLIP_ST_IDLE);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      FG_CLIP_ST_IDLE: begin
        // frame_start in the same cycle as commit_req only arms; the apply waits for the next frame
        if (commit_req) state_d = FG_CLIP_ST_ARMED;
      end
      FG_CLIP_ST_ARMED: begin
        if (frame_start) state_d = FG_CLIP_ST_APPLY;
      end
      FG_CLIP_ST_APPLY: begin
        state_d = FG_CLIP_ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = FG_CLIP_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FG_CLIP_ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FG_CLIP_NUM_EDGES; i++) shadow_q[i] <= '0;
    end else if (wr_fire) begin
      shadow_q[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < FG_CLIP_NUM_EDGES; g++) begin : g_clamp
    fg_clip_clamp #(
      .PRECISION (PRECISION),
      .LIMIT     (((g == FG_CLIP_ADDR_TOP) || (g == FG_CLIP_ADDR_BOTTOM)) ? RESOLUTION_Y : RESOLUTION_X),
      .EN        (CLAMP_EN)
    ) u_clamp (
      .v_i (shadow_q[g]),
      .v_o (applied_v[g])
    );
  end

  // All four edges load on the single APPLY edge so a frame never sees a mix
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FG_CLIP_NUM_EDGES; i++) active_q[i] <= '0;
    end else if (state_q == FG_CLIP_ST_APPLY) begin
      for (int i = 0; i < FG_CLIP_NUM_EDGES; i++) active_q[i] <= applied_v[i];
    end
  end

  assign wr_ready            = (state_q == FG_CLIP_ST_IDLE);
  assign commit_pending      = (state_q != FG_CLIP_ST_IDLE);
  assign commit_done         = done_q;
  assign ctrl_fg_clip_left   = active_q[FG_CLIP_ADDR_LEFT];
  assign ctrl_fg_clip_right  = active_q[FG_CLIP_ADDR_RIGHT];
  assign ctrl_fg_clip_top    = active_q[FG_CLIP_ADDR_TOP];
  assign ctrl_fg_clip_bottom = active_q[FG_CLIP_ADDR_BOTTOM];

endmodule

// File: tb/tb_pipeline_foreground_clip_ctrl.sv
// tb/tb_pipeline_foreground_clip_ctrl.sv - directed self-checking bench for pipeline_foreground_clip_ctrl
// Clamp expectations follow FG_CLIP_CLAMP_EN when the bench is built with it.
module tb_pipeline_foreground_clip_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [1:0]  wr_addr;
  logic [10:0] wr_data;
  logic        wr_ready;
  logic        commit_req;
  logic        frame_start;
  logic        commit_pending;
  logic        commit_done;
  logic [10:0] left, right, top, bottom;

  int n_vec = 0;
  int n_mis = 0;
  int done_cnt = 0;
  int done_base;

  pipeline_foreground_clip_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .wr_valid            (wr_valid),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_ready            (wr_ready),
    .commit_req          (commit_req),
    .frame_start         (frame_start),
    .commit_pending      (commit_pending),
    .commit_done         (commit_done),
    .ctrl_fg_clip_left   (left),
    .ctrl_fg_clip_right  (right),
    .ctrl_fg_clip_top    (top),
    .ctrl_fg_clip_bottom (bottom)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (commit_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [10:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  // frame_start sampled at edge N, active regs valid after edge N+1
  task automatic frame_apply();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit_req = 1'b0; frame_start = 1'b0;
    #12;
    chk("rst_left", left, 0);
    chk("rst_bottom", bottom, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_pending", commit_pending, 0);
    chk("rst_done", commit_done, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // atomic apply
    wr(2'd0, 11'd10); wr(2'd1, 11'd20); wr(2'd2, 11'd30); wr(2'd3, 11'd40);
    done_base = done_cnt;
    pulse_commit();
    chk("armed_pending", commit_pending, 1);
    chk("armed_wr_ready", wr_ready, 0);
    for (int i = 0; i < 50; i++) begin
      if (left != 0 || right != 0 || top != 0 || bottom != 0) chk("early_apply", {left, right, top[9:0]}, 0);
      tick();
    end
    chk("hold_left", left, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("edgeN_left", left, 0);
    chk("edgeN_pending", commit_pending, 1);
    tick();
    chk("apply_left", left, 10);
    chk("apply_right", right, 20);
    chk("apply_top", top, 30);
    chk("apply_bottom", bottom, 40);
    chk("apply_done", commit_done, 1);
    chk("apply_pending", commit_pending, 0);
    tick();
    chk("done_low", commit_done, 0);
    repeat (3) tick();
    chk("done_once", done_cnt - done_base, 1);

    // hold-off of a write while armed
    pulse_commit();
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 11'd99;
    repeat (3) tick();
    chk("holdoff_ready", wr_ready, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("holdoff_left", left, 10);
    chk("holdoff_ready_idle", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    pulse_commit();
    frame_apply();
    chk("held_write_left", left, 99);
    chk("held_write_right", right, 20);

    // commit_req with frame_start together: arm only
    wr(2'd0, 11'd5);
    commit_req = 1'b1; frame_start = 1'b1;
    tick();
    commit_req = 1'b0; frame_start = 1'b0;
    repeat (3) tick();
    chk("same_cycle_left", left, 99);
    chk("same_cycle_pending", commit_pending, 1);
    frame_apply();
    chk("same_cycle_next_left", left, 5);

    // clamp
    wr(2'd1, 11'd1000); wr(2'd3, 11'd700);
    pulse_commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
`ifdef FG_CLIP_CLAMP_EN
    chk("clamp_right", right, 800);
    chk("clamp_bottom", bottom, 600);
`else
    chk("clamp_right", right, 1000);
    chk("clamp_bottom", bottom, 700);
`endif
    chk("clamp_top", top, 30);

    // back-to-back commit during commit_done, with a write in the same cycle
    chk("b2b_done", commit_done, 1);
    commit_req = 1'b1; wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 11'd7;
    tick();
    commit_req = 1'b0; wr_valid = 1'b0;
    chk("b2b_pending", commit_pending, 1);
    chk("b2b_left_old", left, 5);
    repeat (2) tick();
    frame_apply();
    chk("b2b_left_new", left, 7);
    chk("b2b_done2", commit_done, 1);
    tick();

    // async reset while armed
    pulse_commit();
    chk("pre_rst_pending", commit_pending, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_left", left, 0);
    chk("arst_right", right, 0);
    chk("arst_top", top, 0);
    chk("arst_bottom", bottom, 0);
    chk("arst_wr_ready", wr_ready, 1);
    chk("arst_pending", commit_pending, 0);
    chk("arst_done", commit_done, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
